// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: grants up to three of four producers per cycle onto the register-file write ports.
// Optional carry-bit arbitration is enabled by defining WB_CARRY_EN.
module regfile_wb_arbiter #(
    parameter int AW = 6,
    parameter int DW = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [3:0]        req_valid,
    output logic [3:0]        req_ready,
    input  logic [4*AW-1:0]   req_reg,
    input  logic [4*DW-1:0]   req_data,
    input  logic [3:0]        req_carry_en,
    input  logic [3:0]        req_carry,
    output logic [AW-1:0]     reg_wr1,
    output logic [DW-1:0]     reg_wr1_data,
    output logic              reg_wr1_enable,
    output logic [AW-1:0]     reg_wr2,
    output logic [DW-1:0]     reg_wr2_data,
    output logic              reg_wr2_enable,
    output logic [AW-1:0]     reg_wr3,
    output logic [DW-1:0]     reg_wr3_data,
    output logic              reg_wr3_enable,
    output logic              carrybit_wr,
    output logic              carrybit_wr_enable
);
    localparam int NREQ  = 4;
    localparam int NPORT = 3;

    logic [AW-1:0] reg_a  [NREQ];
    logic [DW-1:0] data_a [NREQ];
    logic [1:0]    rr;
    logic [3:0]    grant;
    logic [1:0]    sel    [NPORT];
    logic [NPORT-1:0] sel_en;
    logic [AW-1:0] g_reg  [NPORT];
    logic [1:0]    n_grant;
    logic [1:0]    idx;
    logic          conflict;
    logic          denied_found;
    logic [1:0]    first_denied;

    logic [AW-1:0] wr_addr_q [NPORT];
    logic [DW-1:0] wr_data_q [NPORT];
    logic [NPORT-1:0] wr_en_q;

`ifdef WB_CARRY_EN
    logic carry_taken;
    logic carry_val;
    logic carry_q;
    logic carry_we_q;
`else
    logic unused_carry;
    assign unused_carry = ^{req_carry_en, req_carry};
`endif

    always_comb begin
        for (int unsigned j = 0; j < NREQ; j++) begin
            reg_a[j]  = req_reg[j*AW +: AW];
            data_a[j] = req_data[j*DW +: DW];
        end
    end

    // Scan from rr; the k-th grant lands on write port k, the first denial seeds next rr.
    always_comb begin
        grant        = '0;
        sel_en       = '0;
        sel          = '{default: '0};
        g_reg        = '{default: '0};
        n_grant      = '0;
        idx          = '0;
        conflict     = 1'b0;
        denied_found = 1'b0;
        first_denied = rr;
`ifdef WB_CARRY_EN
        carry_taken  = 1'b0;
        carry_val    = 1'b0;
`endif
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = rr + 2'(i);
            if (req_valid[idx]) begin
                conflict = 1'b0;
                for (int unsigned k = 0; k < NPORT; k++) begin
                    if ((2'(k) < n_grant) && (g_reg[k] == reg_a[idx]))
                        conflict = 1'b1;
                end
`ifdef WB_CARRY_EN
                if (req_carry_en[idx] && carry_taken)
                    conflict = 1'b1;
`endif
                if ((n_grant < 2'd3) && !conflict) begin
                    grant[idx]      = 1'b1;
                    sel_en[n_grant] = 1'b1;
                    sel[n_grant]    = idx;
                    g_reg[n_grant]  = reg_a[idx];
                    n_grant         = n_grant + 2'd1;
`ifdef WB_CARRY_EN
                    if (req_carry_en[idx]) begin
                        carry_taken = 1'b1;
                        carry_val   = req_carry[idx];
                    end
`endif
                end else if (!denied_found) begin
                    denied_found = 1'b1;
                    first_denied = idx;
                end
            end
        end
    end

    assign req_ready = reset ? '0 : grant;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr        <= '0;
            wr_en_q   <= '0;
            wr_addr_q <= '{default: '0};
            wr_data_q <= '{default: '0};
`ifdef WB_CARRY_EN
            carry_q    <= 1'b0;
            carry_we_q <= 1'b0;
`endif
        end else begin
            rr <= denied_found ? first_denied : rr + 2'd1;
            for (int unsigned k = 0; k < NPORT; k++) begin
                wr_en_q[k] <= sel_en[k];
                if (sel_en[k]) begin
                    wr_addr_q[k] <= reg_a[sel[k]];
                    wr_data_q[k] <= data_a[sel[k]];
                end
            end
`ifdef WB_CARRY_EN
            carry_we_q <= carry_taken;
            if (carry_taken)
                carry_q <= carry_val;
`endif
        end
    end

    assign reg_wr1        = wr_addr_q[0];
    assign reg_wr1_data   = wr_data_q[0];
    assign reg_wr1_enable = wr_en_q[0];
    assign reg_wr2        = wr_addr_q[1];
    assign reg_wr2_data   = wr_data_q[1];
    assign reg_wr2_enable = wr_en_q[1];
    assign reg_wr3        = wr_addr_q[2];
    assign reg_wr3_data   = wr_data_q[2];
    assign reg_wr3_enable = wr_en_q[2];
`ifdef WB_CARRY_EN
    assign carrybit_wr        = carry_q;
    assign carrybit_wr_enable = carry_we_q;
`else
    assign carrybit_wr        = 1'b0;
    assign carrybit_wr_enable = 1'b0;
`endif

endmodule
